// File: rtl/jtopl_pkg.sv
// Shared constants for the OPL timer block and the register interface.
package jtopl_pkg;

  // Timer counter / preset width
  localparam int unsigned JT_CW    = 8;
  // Timer 2 prescaler width: Timer 2 advances once per 2**JT_PRE_W ticks
  localparam int unsigned JT_PRE_W = 2;

endpackage

// File: rtl/jtopl_timers_if.sv
// Register-side levels/pulses into the timers and status/strobes back out.
interface jtopl_timers_if
  import jtopl_pkg::*;
#(
  parameter int unsigned CW = JT_CW
);

  logic          tick;
  logic [CW-1:0] value_a;
  logic [CW-1:0] value_b;
  logic          load_a;
  logic          load_b;
  logic          mask_a;
  logic          mask_b;
  logic          clr_flags;
  logic          flag_a;
  logic          flag_b;
  logic          irq_n;
  logic          ovf_a;
  logic          ovf_b;

  modport master (
    output tick, value_a, value_b, load_a, load_b, mask_a, mask_b, clr_flags,
    input  flag_a, flag_b, irq_n, ovf_a, ovf_b
  );

  modport slave (
    input  tick, value_a, value_b, load_a, load_b, mask_a, mask_b, clr_flags,
    output flag_a, flag_b, irq_n, ovf_a, ovf_b
  );

endinterface

// File: rtl/jtopl_timer.sv
// One OPL interval timer: start-edge load, up-count, reload on overflow,
// registered overflow strobe and maskable status flag.
module jtopl_timer
  import jtopl_pkg::*;
#(
  parameter int unsigned W = JT_CW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         load,
  input  logic         mask,
  input  logic         clr,
  input  logic [W-1:0] value,
  output logic         ovf,
  output logic         flag
);

  logic [W-1:0] cnt;
  logic         load_q;
  logic         start;
  logic         wrap;

  // Start edge beats a coincident step; wrap only while running
  always_comb begin
    start = load & ~load_q;
    wrap  = ~start & load & step & (cnt == '1);
  end

  // Counter, load history and overflow strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      load_q <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      load_q <= load;
      ovf    <= wrap;
      if (start || wrap) begin
        cnt <= value;
      end else if (load && step) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Status flag: mask forces clear, a set outranks a coincident clear
  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= 1'b0;
    end else if (mask) begin
      flag <= 1'b0;
    end else if (wrap) begin
      flag <= 1'b1;
    end else if (clr) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/jtopl_timers.sv
// OPL Timer 1 / Timer 2 with Timer 2 prescaler and active-low IRQ combine.
module jtopl_timers
  import jtopl_pkg::*;
#(
  parameter int unsigned CW    = JT_CW,
  parameter int unsigned PRE_W = JT_PRE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  jtopl_timers_if.slave        bus
);

  logic [PRE_W-1:0] pre;
  logic             step_b;

  // Free-running Timer 2 prescaler, advanced by every tick
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (bus.tick) begin
      pre <= pre + 1'b1;
    end
  end

  // Timer 2 steps on the tick that wraps the prescaler; IRQ from flags
  always_comb begin
    step_b    = bus.tick & (pre == '1);
    bus.irq_n = ~(bus.flag_a | bus.flag_b);
  end

  jtopl_timer #(.W(CW)) u_timer_a (
    .clk   (clk),
    .rst   (rst),
    .step  (bus.tick),
    .load  (bus.load_a),
    .mask  (bus.mask_a),
    .clr   (bus.clr_flags),
    .value (bus.value_a),
    .ovf   (bus.ovf_a),
    .flag  (bus.flag_a)
  );

  jtopl_timer #(.W(CW)) u_timer_b (
    .clk   (clk),
    .rst   (rst),
    .step  (step_b),
    .load  (bus.load_b),
    .mask  (bus.mask_b),
    .clr   (bus.clr_flags),
    .value (bus.value_b),
    .ovf   (bus.ovf_b),
    .flag  (bus.flag_b)
  );

endmodule

// File: tb/tb_jtopl_timers.sv
// Randomised bench for jtopl_timers against a steps-remaining reference model.
module tb_jtopl_timers;

  localparam int CW    = 8;
  localparam int PRE_W = 2;
  localparam int FULL  = 1 << CW;
  localparam int PDIV  = 1 << PRE_W;

  logic clk = 1'b0;
  logic rst;

  jtopl_timers_if #(.CW(CW)) bus ();

  jtopl_timers #(.CW(CW), .PRE_W(PRE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: ticks seen since reset, and per timer the number of
  // steps still to go before the next overflow.
  int m_ticks;
  int m_rem  [2];
  bit m_prev [2];
  bit m_flag [2];
  bit m_ovf  [2];

  task automatic model_step();
    bit st [2];
    bit ld [2];
    bit mk [2];
    int v  [2];
    if (rst) begin
      m_ticks = 0;
      for (int i = 0; i < 2; i++) begin
        m_rem[i] = FULL; m_prev[i] = 0; m_flag[i] = 0; m_ovf[i] = 0;
      end
      return;
    end
    st[0] = bus.tick;
    st[1] = bus.tick && ((m_ticks % PDIV) == PDIV - 1);
    if (bus.tick) m_ticks++;
    ld[0] = bus.load_a; ld[1] = bus.load_b;
    mk[0] = bus.mask_a; mk[1] = bus.mask_b;
    v[0]  = int'(bus.value_a); v[1] = int'(bus.value_b);
    for (int i = 0; i < 2; i++) begin
      m_ovf[i] = 0;
      if (ld[i] && !m_prev[i]) begin
        m_rem[i] = FULL - v[i];
      end else if (ld[i] && st[i]) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_ovf[i] = 1;
          m_rem[i] = FULL - v[i];
        end
      end
      m_prev[i] = ld[i];
      if (mk[i])          m_flag[i] = 0;
      else if (m_ovf[i])  m_flag[i] = 1;
      else if (bus.clr_flags) m_flag[i] = 0;
    end
  endtask

  function automatic logic [4:0] expv();
    return {m_flag[0], m_flag[1], ~(m_flag[0] | m_flag[1]), m_ovf[0], m_ovf[1]};
  endfunction

  function automatic logic [4:0] obsv();
    return {bus.flag_a, bus.flag_b, bus.irq_n, bus.ovf_a, bus.ovf_b};
  endfunction

  // Advance one clock with the inputs currently driven
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_tick();
    return !bus.tick && ($urandom_range(0, 1) == 1);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.tick = 0; bus.value_a = '0; bus.value_b = '0;
    bus.load_a = 0; bus.load_b = 0; bus.mask_a = 0; bus.mask_b = 0;
    bus.clr_flags = 0;
    cyc(); cyc();
    checks++;
    if (obsv() !== 5'b00100) begin
      fails++;
      $display("FAIL reset: got %b want %b (fa fb irq_n oa ob)", obsv(), 5'b00100);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.tick = (i % 2 == 0);
      cyc();
      checks++;
      if (obsv() !== 5'b00100) begin
        fails++;
        $display("FAIL idle[%0d]: got %b want %b", i, obsv(), 5'b00100);
      end
    end
  endtask

  task automatic test_timer_a();
    bus.tick = 0; bus.value_a = 8'hFE; bus.load_a = 1;
    cyc();
    // first tick: FE->FF, no overflow
    bus.tick = 1; cyc(); bus.tick = 0; cyc();
    checks++;
    if (bus.ovf_a !== 1'b0) begin
      fails++; $display("FAIL fe_first_tick: ovf_a got %b want 0", bus.ovf_a);
    end
    // second tick: overflow, flag and IRQ
    bus.tick = 1; cyc();
    checks++;
    if ({bus.ovf_a, bus.flag_a, bus.irq_n} !== 3'b110) begin
      fails++;
      $display("FAIL fe_second_tick: ovf/flag/irq_n got %b want 110",
               {bus.ovf_a, bus.flag_a, bus.irq_n});
    end
    bus.tick = 0; cyc();
    checks++;
    if (bus.ovf_a !== 1'b0) begin
      fails++; $display("FAIL fe_strobe_width: ovf_a got %b want 0", bus.ovf_a);
    end
    for (int i = 0; i < 60; i++) begin
      bus.tick = rnd_tick();
      cyc();
      checks++;
      if (obsv() !== expv()) begin
        fails++; $display("FAIL timer_a[%0d]: got %b want %b", i, obsv(), expv());
      end
    end
  endtask

  task automatic test_timer_b();
    int nb;
    nb = 0;
    bus.tick = 0; bus.value_b = 8'hFF; bus.load_b = 1;
    for (int i = 0; i < 80; i++) begin
      bus.tick = rnd_tick();
      cyc();
      if (bus.ovf_b === 1'b1) nb++;
      checks++;
      if (obsv() !== expv()) begin
        fails++; $display("FAIL timer_b[%0d]: got %b want %b", i, obsv(), expv());
      end
    end
    checks++;
    if (nb == 0) begin
      fails++; $display("FAIL timer_b_active: ovf_b count got 0 want >0");
    end
  endtask

  task automatic test_mask();
    bus.tick = 0; bus.value_a = 8'hFF;
    // ensure flag_a is up before masking
    for (int i = 0; i < 8; i++) begin
      bus.tick = rnd_tick() | (i == 6);
      if (i == 7) bus.tick = 0;
      cyc();
    end
    checks++;
    if (bus.flag_a !== 1'b1) begin
      fails++; $display("FAIL mask_pre: flag_a got %b want 1", bus.flag_a);
    end
    bus.mask_a = 1; cyc();
    checks++;
    if (bus.flag_a !== 1'b0) begin
      fails++; $display("FAIL mask_clear: flag_a got %b want 0", bus.flag_a);
    end
    for (int i = 0; i < 30; i++) begin
      bus.tick = rnd_tick();
      cyc();
      checks++;
      if ({bus.ovf_a, bus.flag_a} !== {m_ovf[0], 1'b0} || obsv() !== expv()) begin
        fails++; $display("FAIL mask_run[%0d]: got %b want %b", i, obsv(), expv());
      end
    end
    bus.tick = 0; bus.mask_a = 0; cyc();
  endtask

  task automatic test_clr();
    // value_a=FF: every tick overflows, so clr on a tick collides with a set
    bus.load_b = 0; bus.mask_b = 1;
    bus.tick = 0; cyc();
    bus.mask_b = 0;
    bus.tick = 1; bus.clr_flags = 1; cyc();
    checks++;
    if ({bus.flag_a, bus.irq_n} !== 2'b10) begin
      fails++;
      $display("FAIL clr_vs_set: flag_a/irq_n got %b want 10", {bus.flag_a, bus.irq_n});
    end
    bus.tick = 0; bus.clr_flags = 1; cyc();
    checks++;
    if ({bus.flag_a, bus.flag_b, bus.irq_n} !== 3'b001) begin
      fails++;
      $display("FAIL clr_plain: fa/fb/irq_n got %b want 001",
               {bus.flag_a, bus.flag_b, bus.irq_n});
    end
    bus.clr_flags = 0; cyc();
  endtask

  task automatic test_start_coincident();
    int nt;
    int hit;
    bus.load_a = 0; bus.tick = 0; cyc();
    bus.value_a = 8'h10; bus.load_a = 1; bus.tick = 1; cyc();
    nt = 0; hit = -1;
    for (int i = 0; i < 600 && hit < 0; i++) begin
      bus.tick = (i % 2 == 1);
      if (bus.tick) nt++;
      cyc();
      if (bus.ovf_a === 1'b1) hit = nt;
      checks++;
      if (obsv() !== expv()) begin
        fails++; $display("FAIL start_run[%0d]: got %b want %b", i, obsv(), expv());
      end
    end
    checks++;
    if (hit != FULL - 'h10) begin
      fails++; $display("FAIL start_period: ticks to ovf got %0d want %0d", hit, FULL - 'h10);
    end
  endtask

  task automatic test_rst_mid();
    bus.tick = 1; bus.load_b = 1; bus.value_a = 8'hFF; cyc();
    bus.tick = 0; cyc();
    bus.tick = 1; rst = 1; cyc();
    checks++;
    if (obsv() !== 5'b00100) begin
      fails++; $display("FAIL rst_mid: got %b want 00100", obsv());
    end
    rst = 0; bus.tick = 0; cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      bus.tick = rnd_tick();
      if ($urandom_range(0, 63) == 0) bus.load_a = ~bus.load_a;
      if ($urandom_range(0, 63) == 0) bus.load_b = ~bus.load_b;
      if ($urandom_range(0, 31) == 0) bus.value_a = 8'($urandom_range(240, 255));
      if ($urandom_range(0, 31) == 0) bus.value_b = 8'($urandom_range(248, 255));
      if ($urandom_range(0, 99) == 0) bus.mask_a = ~bus.mask_a;
      if ($urandom_range(0, 99) == 0) bus.mask_b = ~bus.mask_b;
      bus.clr_flags = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cyc();
      checks++;
      if (obsv() !== expv()) begin
        fails++; $display("FAIL random[%0d]: got %b want %b", i, obsv(), expv());
      end
    end
    rst = 0; bus.clr_flags = 0;
  endtask

  initial begin
    test_reset();
    test_timer_a();
    test_timer_b();
    test_mask();
    test_clr();
    test_start_coincident();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
